// File: rtl/fetch_unit_pkg.sv
// Shared widths, fetch FSM state encoding and capture-buffer entry type for the fetch stage.
package constants;
  localparam int unsigned ADDR_SIZE = 19;
  localparam int unsigned DATA_SIZE = 19;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} fetch_state_t;

  typedef struct packed {
    logic [DATA_SIZE-1:0] instr;
    logic [ADDR_SIZE-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_buffer.sv
// Capture buffer between memory return and the IR: 1 or 2 entries, head-first, synchronous flush.
module fetch_buffer
  import constants::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  output logic         out_valid,
  input  logic         out_ready,
  output fetch_entry_t out_entry,
  output logic [1:0]   count
);

  logic         pop;
  logic [1:0]   count_next;
  fetch_entry_t head_next;
  fetch_entry_t second;
  fetch_entry_t second_next;

  assign pop = out_valid && out_ready;

  // Head always presents the oldest entry; second only exists for the 2-deep build.
  always_comb begin
    count_next  = count;
    head_next   = out_entry;
    second_next = second;
    if (flush) begin
      count_next  = '0;
      head_next   = '0;
      second_next = '0;
    end else begin
      count_next = count + 2'(push) - 2'(pop);
      if (pop && DEPTH > 1) head_next = second;
      if (push) begin
        if (count == 2'd0 || (count == 2'd1 && pop)) head_next = push_entry;
        else second_next = push_entry;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      out_valid <= 1'b0;
      out_entry <= '0;
      second    <= '0;
    end else begin
      count     <= count_next;
      out_valid <= (count_next != 2'd0);
      out_entry <= head_next;
      second    <= second_next;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, memory req/ack, IR valid/ready and jump redirect handling.
// Define FETCH_SKID_EN for a 2-entry capture buffer that keeps fetching while the IR stalls.
module fetch_unit #(
  parameter int unsigned          ADDR_SIZE    = constants::ADDR_SIZE,
  parameter int unsigned          DATA_SIZE    = constants::DATA_SIZE,
  parameter logic [ADDR_SIZE-1:0] RESET_VECTOR = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 halt,
  input  logic                 jmp_valid,
  input  logic [ADDR_SIZE-1:0] jmp_addr,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic                 mem_req,
  input  logic                 mem_ack,
  input  logic [DATA_SIZE-1:0] mem_rdata,
  output logic                 ir_valid,
  input  logic                 ir_ready,
  output logic [DATA_SIZE-1:0] ir_instr,
  output logic [ADDR_SIZE-1:0] ir_pc
);
  import constants::*;

`ifdef FETCH_SKID_EN
  localparam int unsigned DEPTH = 2;
`else
  localparam int unsigned DEPTH = 1;
`endif

  fetch_state_t         state, state_next;
  logic [ADDR_SIZE-1:0] pc, pc_next, addr_next;
  logic                 req_next;
  logic                 push, pop, fills;
  logic [1:0]           buf_count, cnt_after;
  fetch_entry_t         push_entry, buf_out;

  assign pop        = ir_valid && ir_ready;
  assign cnt_after  = buf_count + 2'd1 - 2'(pop);
  assign fills      = (cnt_after == 2'(DEPTH));
  assign push_entry = '{instr: mem_rdata, pc: mem_addr};
  assign ir_instr   = buf_out.instr;
  assign ir_pc      = buf_out.pc;

  // Next state; mem_addr only moves when a new request starts, so an un-acked request stays stable.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    addr_next  = mem_addr;
    push       = 1'b0;
    unique case (state)
      IDLE, HOLD: begin
        if (jmp_valid) begin
          pc_next    = jmp_addr;
          state_next = halt ? IDLE : FETCH;
          addr_next  = halt ? mem_addr : jmp_addr;
        end else if (state == IDLE || pop) begin
          state_next = halt ? IDLE : FETCH;
          addr_next  = halt ? mem_addr : pc;
        end
      end
      FETCH: begin
        if (jmp_valid) begin
          pc_next = jmp_addr;
          if (mem_ack) begin
            state_next = halt ? IDLE : FETCH;
            addr_next  = halt ? mem_addr : jmp_addr;
          end else begin
            state_next = DISCARD;
          end
        end else if (mem_ack) begin
          push    = 1'b1;
          pc_next = pc + ADDR_SIZE'(1);
          if (fills) begin
            state_next = HOLD;
          end else if (halt) begin
            state_next = IDLE;
          end else begin
            state_next = FETCH;
            addr_next  = pc_next;
          end
        end
      end
      DISCARD: begin
        if (jmp_valid) pc_next = jmp_addr;
        if (mem_ack) begin
          state_next = halt ? IDLE : FETCH;
          addr_next  = halt ? mem_addr : pc_next;
        end
      end
      default: state_next = IDLE;
    endcase
    req_next = (state_next == FETCH) || (state_next == DISCARD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_VECTOR;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      mem_req  <= req_next;
      mem_addr <= addr_next;
    end
  end

  fetch_buffer #(.DEPTH(DEPTH)) u_buffer (
    .clk       (clk),
    .rst       (rst),
    .flush     (jmp_valid),
    .push      (push),
    .push_entry(push_entry),
    .out_valid (ir_valid),
    .out_ready (ir_ready),
    .out_entry (buf_out),
    .count     (buf_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (single-entry buffer build).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic        jmp_valid;
  logic [18:0] jmp_addr;
  logic [18:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [18:0] mem_rdata;
  logic        ir_valid;
  logic        ir_ready;
  logic [18:0] ir_instr;
  logic [18:0] ir_pc;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit dut (
    .clk      (clk),
    .rst      (rst),
    .halt     (halt),
    .jmp_valid(jmp_valid),
    .jmp_addr (jmp_addr),
    .mem_addr (mem_addr),
    .mem_req  (mem_req),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .ir_valid (ir_valid),
    .ir_ready (ir_ready),
    .ir_instr (ir_instr),
    .ir_pc    (ir_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%05h expected 0x%05h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; halt = 1'b0; jmp_valid = 1'b0; jmp_addr = '0;
    mem_ack = 1'b0; mem_rdata = '0; ir_ready = 1'b0;
    tick(); tick();
    check("rst_req",   32'(mem_req),  0);
    check("rst_valid", 32'(ir_valid), 0);
    check("rst_addr",  32'(mem_addr), 0);
    check("rst_instr", 32'(ir_instr), 0);
    check("rst_pc",    32'(ir_pc),    0);

    // First fetch, ack after two cycles
    rst = 1'b0;
    tick();
    check("f1_req",  32'(mem_req),  1);
    check("f1_addr", 32'(mem_addr), 'h00000);
    tick();
    mem_ack = 1'b1; mem_rdata = 19'h1ABCD; ir_ready = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("f1_valid", 32'(ir_valid), 1);
    check("f1_instr", 32'(ir_instr), 'h1ABCD);
    check("f1_pc",    32'(ir_pc),    'h00000);
    check("f1_reqlo", 32'(mem_req),  0);
    tick();
    check("f2_req",   32'(mem_req),  1);
    check("f2_addr",  32'(mem_addr), 'h00001);
    check("f2_valid", 32'(ir_valid), 0);

    // IR stall for five cycles
    ir_ready = 1'b0; mem_ack = 1'b1; mem_rdata = 19'h00111;
    tick();
    mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(ir_valid), 1);
      check("stall_instr", 32'(ir_instr), 'h00111);
      check("stall_pc",    32'(ir_pc),    'h00001);
      check("stall_req",   32'(mem_req),  0);
      tick();
    end
    ir_ready = 1'b1;
    tick();
    check("unstall_req",  32'(mem_req),  1);
    check("unstall_addr", 32'(mem_addr), 'h00002);

    // Redirect to 0x10 while fetch of 0x2 is pending
    jmp_valid = 1'b1; jmp_addr = 19'h00010;
    tick();
    jmp_valid = 1'b0;
    check("disc_req",  32'(mem_req),  1);
    check("disc_addr", 32'(mem_addr), 'h00002);
    mem_ack = 1'b1; mem_rdata = 19'h2DEAD;
    tick();
    mem_ack = 1'b0;
    check("disc_valid", 32'(ir_valid), 0);
    check("disc_new",   32'(mem_addr), 'h00010);

    // Redirect to 0x400 while 0x10 is un-acked, ack three cycles later
    jmp_valid = 1'b1; jmp_addr = 19'h00400;
    tick();
    jmp_valid = 1'b0;
    check("j400_hold0", 32'(mem_addr), 'h00010);
    check("j400_req",   32'(mem_req),  1);
    tick();
    check("j400_hold1", 32'(mem_addr), 'h00010);
    tick();
    check("j400_hold2", 32'(mem_addr), 'h00010);
    mem_ack = 1'b1; mem_rdata = 19'h3BEEF;
    tick();
    mem_ack = 1'b0;
    check("j400_drop", 32'(ir_valid), 0);
    check("j400_addr", 32'(mem_addr), 'h00400);
    check("j400_req2", 32'(mem_req),  1);

    // Redirect coincident with ack
    mem_ack = 1'b1; mem_rdata = 19'h12345; jmp_valid = 1'b1; jmp_addr = 19'h7FFFF;
    tick();
    mem_ack = 1'b0; jmp_valid = 1'b0;
    check("jack_valid", 32'(ir_valid), 0);
    check("jack_addr",  32'(mem_addr), 'h7FFFF);
    check("jack_req",   32'(mem_req),  1);

    // PC wrap at top of address space
    mem_ack = 1'b1; mem_rdata = 19'h05555;
    tick();
    mem_ack = 1'b0;
    check("wrap_valid", 32'(ir_valid), 1);
    check("wrap_pc",    32'(ir_pc),    'h7FFFF);
    check("wrap_instr", 32'(ir_instr), 'h05555);
    tick();
    check("wrap_req",  32'(mem_req),  1);
    check("wrap_addr", 32'(mem_addr), 'h00000);

    // Halt during an outstanding fetch
    halt = 1'b1;
    tick();
    check("halt_keep", 32'(mem_req), 1);
    mem_ack = 1'b1; mem_rdata = 19'h00ABC;
    tick();
    mem_ack = 1'b0;
    check("halt_valid", 32'(ir_valid), 1);
    check("halt_instr", 32'(ir_instr), 'h00ABC);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("halt_noreq", 32'(mem_req), 0);
    end
    check("halt_empty", 32'(ir_valid), 0);
    halt = 1'b0;
    tick();
    check("resume_req",  32'(mem_req),  1);
    check("resume_addr", 32'(mem_addr), 'h00001);

    // Reset mid-request clears outputs immediately
    rst = 1'b1;
    #1;
    check("arst_req",   32'(mem_req),  0);
    check("arst_valid", 32'(ir_valid), 0);
    rst = 1'b0;
    tick();
    check("arst_restart", 32'(mem_req),  1);
    check("arst_addr",    32'(mem_addr), 'h00000);

    // Redirect while holding a word flushes it
    ir_ready = 1'b0; mem_ack = 1'b1; mem_rdata = 19'h0F0F0;
    tick();
    mem_ack = 1'b0;
    check("hj_valid", 32'(ir_valid), 1);
    jmp_valid = 1'b1; jmp_addr = 19'h00055;
    tick();
    jmp_valid = 1'b0;
    check("hj_flush", 32'(ir_valid), 0);
    check("hj_req",   32'(mem_req),  1);
    check("hj_addr",  32'(mem_addr), 'h00055);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 19-bit CPU. It owns the program counter and drives instruction addresses onto the address bus toward memory via a req/ack handshake. It captures each returned instruction word and hands it to the instruction register with a valid/ready handshake. It accepts jump redirects from execute and discards any in-flight fetch they invalidate.

## Interface
- `ADDR_SIZE`, default `constants::ADDR_SIZE` (19): address and PC width.
- `DATA_SIZE`, default `constants::DATA_SIZE` (19): instruction word width.
- `RESET_VECTOR`, default `'0`: PC value after reset.
- `clk`  input  1  single clock; all state changes on its rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `halt`  input  1  when high, no new fetch request is started.
- `jmp_valid`  input  1  redirect strobe, one cycle.
- `jmp_addr`  input  ADDR_SIZE  redirect target.
- `mem_addr`  output  ADDR_SIZE  fetch address; drives the address bus `in_address` at memory.
- `mem_req`  output  1  fetch request.
- `mem_ack`  input  1  one-cycle acknowledge; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  input  DATA_SIZE  fetched word.
- `ir_valid`  output  1  instruction available to the IR.
- `ir_ready`  input  1  the IR accepts the instruction.
- `ir_instr`  output  DATA_SIZE  instruction word.
- `ir_pc`  output  ADDR_SIZE  address the instruction was fetched from.

## Operation
- States:
  - IDLE: no request outstanding.
  - FETCH: `mem_req` high.
  - HOLD: the buffer is full and the unit is waiting for `ir_ready`.
  - DISCARD: `mem_req` is still high for a stale address, and the word it returns is dropped.
- Reset:
  - State goes to IDLE.
  - `pc` = `RESET_VECTOR`.
  - `mem_req`, `ir_valid` = 0.
  - `mem_addr`, `ir_instr`, `ir_pc` = 0.
- IDLE -> FETCH when `halt` is low. `mem_addr` <= `pc`.
- FETCH, `mem_ack` received:
  - The word is captured together with its address.
  - `pc` <= `pc` + 1, modulo 2^ADDR_SIZE, so 0x7FFFF wraps to 0x00000.
  - Next state is HOLD.
- HOLD, `ir_valid` && `ir_ready`: go to FETCH if `halt` is low, otherwise IDLE.
- The request is held stable: `mem_req` and `mem_addr` never change while a request is un-acked, including on redirect.
- Redirect (`jmp_valid`) has priority over every other event:
  - IDLE or HOLD: `pc` <= `jmp_addr`, buffer cleared, `ir_valid` drops the next cycle. Then go to FETCH, or to IDLE if halted.
  - FETCH without `mem_ack` in the same cycle: `pc` <= `jmp_addr`, go to DISCARD.
  - FETCH with `mem_ack` in the same cycle: the acked word is dropped, `pc` <= `jmp_addr`, go to FETCH (new address next cycle).
  - DISCARD: `pc` <= `jmp_addr` again. The latest jump wins.
- DISCARD, `mem_ack`: the word is dropped and `pc` is unchanged. Go to FETCH, or to IDLE if halted.
- Redirect and IR handshake in the same cycle in HOLD: the transfer completes, because the IR sampled it. `pc` still takes `jmp_addr`.
- `halt` never aborts an outstanding request. It only blocks new ones.
- `rst` asserted mid-request clears everything immediately. Memory must tolerate a dropped request.

## Timing
- `mem_req` rises at the earliest 1 cycle after `rst` deasserts.
- Latency from `mem_ack` in cycle N to `ir_valid` high in cycle N+1.
- Next `mem_req` is high in the cycle after the IR handshake. Throughput is 1 instruction per 3 cycles with zero-wait memory.
- `ir_instr` and `ir_pc` are stable while `ir_valid` is high and `ir_ready` is low.
- Redirect takes effect on `mem_addr` at the first cycle in which a new request starts after the redirect.

## Configuration
- `FETCH_SKID_EN` defined:
  - The capture buffer is a 2-entry FIFO.
  - After an ack, FETCH of `pc`+1 restarts the next cycle while entry 0 waits for the IR.
  - `mem_req` is held low only while both entries are full.
  - Redirect flushes both entries.
  - Zero-wait throughput is 1 instruction per 2 cycles.
- `FETCH_SKID_EN` undefined: single-entry buffer, behaviour exactly as described above.

## Structure
- `constants` package holds:
  - `ADDR_SIZE` and `DATA_SIZE`.
  - `fetch_state_t` enum (IDLE, FETCH, HOLD, DISCARD).
  - `fetch_entry_t` struct with instr and pc fields.
- One sub-module, `fetch_buffer`: 1- or 2-entry valid/ready buffer of `fetch_entry_t` with a synchronous flush input.
- The PC register and the FSM stay in `fetch_unit`.

## Test plan
- Reset release, memory acks after 2 cycles with 0x1ABCD, `ir_ready`=1 -> first `mem_addr`=0x00000, `ir_instr`=0x1ABCD with `ir_pc`=0x00000, then second `mem_addr`=0x00001.
- `ir_ready` held low for 5 cycles with `ir_valid` high -> `ir_instr` and `ir_pc` stable, `mem_req` stays 0 (with skid: exactly one further fetch, then `mem_req`=0).
- `jmp_valid` with `jmp_addr`=0x00400 while a fetch of 0x00010 is un-acked, ack 3 cycles later -> `mem_addr` stays 0x00010 until the ack, word dropped, next `mem_addr`=0x00400.
- `jmp_valid` in the same cycle as `mem_ack` -> no `ir_valid` for that word, next `mem_addr`=`jmp_addr`.
- PC at 0x7FFFF fetched and accepted -> next `mem_addr`=0x00000.
- `halt` raised during FETCH -> the current ack completes and is delivered to the IR, then no further `mem_req` until `halt` falls. `rst` pulsed mid-request -> `mem_req`=0 and `ir_valid`=0 in the same cycle.
